arrow_scheduler: RTL and testbench

//  Beat-driven sequencer that owns the arrow random generator and schedules the arrow stream for one song round.

---
 rtl/arrow_scheduler_pkg.sv | 23 ++
 rtl/arrow_scheduler_lfsr.sv | 38 +++
 rtl/arrow_scheduler.sv | 112 +++++++++++
 tb/tb_arrow_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arrow_scheduler_pkg.sv
// Shared arrow-scheduler definitions: lane geometry, FSM state encoding, arrow decode helper.
// DOUBLE_ARROW_EN (when defined) enables chord arrows in the LFSR sub-module.
package arrow_scheduler_pkg;

  localparam int NUM_ARROWS = 4;
  localparam int LANE_DEPTH = 4;
  localparam int LANE_W     = NUM_ARROWS * LANE_DEPTH;
  localparam logic [5:0] LFSR_RESET = 6'h01;
  localparam logic [5:0] LFSR_LOCK  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic logic [NUM_ARROWS-1:0] one_hot(input logic [1:0] idx);
    return NUM_ARROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/arrow_scheduler_lfsr.sv
// 6-bit XNOR LFSR with load/step enables; the arrow is decoded from the post-step value, 1-cycle update.
// Never stalls; DOUBLE_ARROW_EN turns lfsr[5:4]==2'b11 steps into two-arrow chords.
module ddr_lfsr6
  import arrow_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [5:0]            load_val,
  input  logic                  step,
  output logic [NUM_ARROWS-1:0] arrow
);

  logic [5:0] lfsr_q;
  logic [5:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr_q[4:0], ~(lfsr_q[5] ^ lfsr_q[4])};

`ifdef DOUBLE_ARROW_EN
  // Chord partner sits two positions round the arrow ring (2-bit add wraps mod 4).
  assign arrow = one_hot(lfsr_nxt[1:0])
               | ({NUM_ARROWS{lfsr_nxt[5:4] == 2'b11}} & one_hot(lfsr_nxt[1:0] + 2'd2));
`else
  assign arrow = one_hot(lfsr_nxt[1:0]);
`endif

  // All-ones is the XNOR lock-up state, so it is never allowed in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_RESET;
    end else if (load) begin
      lfsr_q <= (load_val == LFSR_LOCK) ? LFSR_RESET : load_val;
    end else if (step) begin
      lfsr_q <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/arrow_scheduler.sv
// Beat-driven arrow sequencer: seed, 4-cycle lane pre-fill, then one lane shift per unpaused beat.
// Start-to-RUN is 6 cycles; beats outside RUN or while paused are dropped, never deferred.
module arrow_scheduler
  import arrow_scheduler_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int CNT_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  beat_tick,
  input  logic [5:0]            seed,
  output logic [LANE_W-1:0]     lane_arrows,
  output logic [LANE_DEPTH-1:0] lane_valid,
  output logic [CNT_W-1:0]      arrows_left,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_W-1:0] SONG_LEN_C = CNT_W'(SONG_LEN);

  state_t                  state_q, state_d;
  logic [1:0]              fill_cnt_q;
  logic [LANE_W-1:0]       lane_q;
  logic [LANE_DEPTH-1:0]   vld_q;
  logic [CNT_W-1:0]        left_q;
  logic                    lfsr_load;
  logic                    gen;
  logic                    shift;
  logic [NUM_ARROWS-1:0]   arrow;

  ddr_lfsr6 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (gen),
    .arrow    (arrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    gen       = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_SEED;
      end
      ST_SEED: begin
        lfsr_load = 1'b1;
        state_d   = ST_FILL;
      end
      ST_FILL: begin
        gen   = 1'b1;
        shift = 1'b1;
        if (fill_cnt_q == 2'd3) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (vld_q == '0) begin
          state_d = ST_DONE;
        end else if (beat_tick && !pause) begin
          shift = 1'b1;
          gen   = (left_q != '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= (state_q == ST_FILL) ? fill_cnt_q + 2'd1 : 2'd0;
    end
  end

  // New arrows enter at slot3 (top nibble); slot0 (bottom nibble) is the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      vld_q  <= '0;
      left_q <= SONG_LEN_C;
    end else if (state_q == ST_SEED) begin
      lane_q <= '0;
      vld_q  <= '0;
      left_q <= SONG_LEN_C;
    end else if (shift) begin
      lane_q <= {(gen ? arrow : {NUM_ARROWS{1'b0}}), lane_q[LANE_W-1:NUM_ARROWS]};
      vld_q  <= {gen, vld_q[LANE_DEPTH-1:1]};
      if (gen && left_q != '0) left_q <= left_q - CNT_W'(1);
    end
  end

  assign lane_arrows = lane_q;
  assign lane_valid  = vld_q;
  assign arrows_left = left_q;
  assign busy        = (state_q == ST_SEED) || (state_q == ST_FILL) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed bench for arrow_scheduler: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_arrow_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        pause;
  logic        beat_tick;
  logic [5:0]  seed;
  logic [15:0] lane_arrows;
  logic [3:0]  lane_valid;
  logic [5:0]  arrows_left;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

`ifdef DOUBLE_ARROW_EN
  localparam logic [15:0] LANE_B1 = 16'h5888;
  localparam logic [15:0] LANE_B2 = 16'hA588;
`else
  localparam logic [15:0] LANE_B1 = 16'h4888;
  localparam logic [15:0] LANE_B2 = 16'h2488;
`endif

  typedef struct {
    string       name;
    logic        chk_arr;
    logic [15:0] arr;
    logic [3:0]  vld;
    logic        chk_left;
    logic [5:0]  left;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  arrow_scheduler #(.SONG_LEN(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .beat_tick   (beat_tick),
    .seed        (seed),
    .lane_arrows (lane_arrows),
    .lane_valid  (lane_valid),
    .arrows_left (arrows_left),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic ca, input logic [15:0] a,
                            input logic [3:0] v, input logic cl, input logic [5:0] l,
                            input logic b, input logic d);
    exp_t e;
    e.name = nm; e.chk_arr = ca; e.arr = a; e.vld = v;
    e.chk_left = cl; e.left = l; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input string field, input logic [15:0] act,
                       input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_arr) check(e.name, "lane_arrows", lane_arrows, e.arr);
      check(e.name, "lane_valid", {12'h0, lane_valid}, {12'h0, e.vld});
      if (e.chk_left) check(e.name, "arrows_left", {10'h0, arrows_left}, {10'h0, e.left});
      check(e.name, "busy", {15'h0, busy}, {15'h0, e.busy});
      check(e.name, "done", {15'h0, done}, {15'h0, e.done});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] tail [4];
    tail = '{4'h7, 4'h3, 4'h1, 4'h0};
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; beat_tick = 1'b0; seed = 6'h00;

    next_cycle; expect_now("reset", 1, 16'h0, 4'h0, 1, 6'd32, 0, 0);
    rst_n = 1'b1;
    next_cycle; expect_now("idle", 1, 16'h0, 4'h0, 1, 6'd32, 0, 0);

    // start coincident with beat_tick in IDLE: start wins
    start = 1'b1; beat_tick = 1'b1; seed = 6'h01;
    next_cycle; start = 1'b0; beat_tick = 1'b0;
    expect_now("seed", 1, 16'h0, 4'h0, 1, 6'd32, 1, 0);
    next_cycle; expect_now("fill0", 1, 16'h0000, 4'h0, 1, 6'd32, 1, 0);
    next_cycle; expect_now("fill1", 1, 16'h8000, 4'h8, 1, 6'd31, 1, 0);
    next_cycle; expect_now("fill2", 1, 16'h8800, 4'hC, 1, 6'd30, 1, 0);
    next_cycle; expect_now("fill3", 1, 16'h8880, 4'hE, 1, 6'd29, 1, 0);
    next_cycle; expect_now("run0", 1, 16'h8888, 4'hF, 1, 6'd28, 1, 0);
    start = 1'b1;
    next_cycle; start = 1'b0;
    expect_now("run_start_ignored", 1, 16'h8888, 4'hF, 1, 6'd28, 1, 0);

    pause = 1'b1; beat_tick = 1'b1;
    repeat (3) begin
      next_cycle; expect_now("paused_beat", 1, 16'h8888, 4'hF, 1, 6'd28, 1, 0);
    end
    pause = 1'b0;
    next_cycle; expect_now("beat1", 1, LANE_B1, 4'hF, 1, 6'd27, 1, 0);
    next_cycle; beat_tick = 1'b0;
    expect_now("beat2", 1, LANE_B2, 4'hF, 1, 6'd26, 1, 0);

    // asynchronous reset mid-RUN, between clock edges
    next_cycle; rst_n = 1'b0;
    expect_now("arst_mid_run", 1, 16'h0, 4'h0, 1, 6'd32, 0, 0);
    next_cycle; rst_n = 1'b1;
    expect_now("arst_idle", 1, 16'h0, 4'h0, 1, 6'd32, 0, 0);

    // lock-up seed substitutes 6'h01, so the lane repeats the first round
    seed = 6'h3F; start = 1'b1;
    next_cycle; start = 1'b0;
    expect_now("seed_3f", 1, 16'h0, 4'h0, 1, 6'd32, 1, 0);
    next_cycle; expect_now("fill0_3f", 1, 16'h0000, 4'h0, 1, 6'd32, 1, 0);
    next_cycle; expect_now("fill1_3f", 1, 16'h8000, 4'h8, 1, 6'd31, 1, 0);
    next_cycle; expect_now("fill2_3f", 1, 16'h8800, 4'hC, 1, 6'd30, 1, 0);
    next_cycle; expect_now("fill3_3f", 1, 16'h8880, 4'hE, 1, 6'd29, 1, 0);
    next_cycle; expect_now("run0_3f", 1, 16'h8888, 4'hF, 1, 6'd28, 1, 0);

    beat_tick = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      next_cycle; expect_now("song_beat", 0, 16'h0, 4'hF, 1, 6'(28 - i), 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle; expect_now("lane_drain", (k == 3), 16'h0, tail[k], 1, 6'd0, 1, 0);
    end
    next_cycle; expect_now("done", 1, 16'h0, 4'h0, 1, 6'd0, 0, 1);
    next_cycle; expect_now("done_beat_ignored", 1, 16'h0, 4'h0, 1, 6'd0, 0, 1);

    beat_tick = 1'b0; start = 1'b1; seed = 6'h01;
    next_cycle; start = 1'b0;
    expect_now("restart_seed", 1, 16'h0, 4'h0, 0, 6'd0, 1, 0);
    next_cycle; expect_now("restart_fill0", 1, 16'h0, 4'h0, 1, 6'd32, 1, 0);

    next_cycle;
    next_cycle;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
